// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, bit-serial left shift for sll.
// Outputs are registered and hold until the next completion.
module mc_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         ALU_control,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               ovf,
  output logic               illegal,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [SHAMT_W-1:0] cnt_reg;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   op_result;
  logic               op_ovf;
  logic               op_illegal;
  logic [WIDTH-1:0]   acc_shl;
  logic               shift_req;

  assign sum     = A + B;
  assign diff    = A - B;
  assign acc_shl = {acc_reg[WIDTH-2:0], 1'b0};

  // An X opcode compares false here and falls into the single-cycle path as illegal.
  assign shift_req = (ALU_control == OP_SLL) && (shamt != '0);

  // Single-cycle datapath evaluated directly on the inputs at the start edge.
  always_comb begin
    op_result  = '0;
    op_ovf     = 1'b0;
    op_illegal = 1'b0;
    case (ALU_control)
      OP_ADD: begin
        op_result = sum;
        op_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        op_result = diff;
        op_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: op_result = A & B;
      OP_OR:  op_result = A | B;
      OP_NOR: op_result = ~(A | B);
      OP_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: op_result = B;  // only reached with shamt == 0
      default: op_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            if (shift_req) begin
              acc_reg   <= B;
              cnt_reg   <= shamt;
              state_reg <= SHIFT;
              busy      <= 1'b1;
              done      <= 1'b0;
            end else begin
              result    <= op_result;
              zero      <= (op_result == '0);
              ovf       <= op_ovf;
              illegal   <= op_illegal;
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
          end
        end
        SHIFT: begin
          // start is deliberately not looked at while shifting.
          acc_reg <= acc_shl;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == SHAMT_W'(1)) begin
            result    <= acc_shl;
            zero      <= (acc_shl == '0);
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_mc_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ALU_control = 4'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        zero, ovf, illegal, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  mc_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_control(ALU_control),
    .A(A), .B(B), .shamt(shamt), .result(result), .zero(zero),
    .ovf(ovf), .illegal(illegal), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model built from the operation definitions using wide signed arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int sh, output logic [31:0] r, output logic o,
                       output logic il, output int lat);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0; r = '0; o = 1'b0; il = 1'b0; lat = 1;
    if ($isunknown(op)) il = 1'b1;
    else case (op)
      4'b0010: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1111: begin r = b << sh; lat = sh + 1; end
      default: il = 1'b1;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input bit poke);
    logic [31:0] er;
    logic eo, eil;
    int elat, cyc;
    model(op, a, b, int'(sh), er, eo, eil, elat);
    @(negedge clk);
    start = 1'b1; ALU_control = op; A = a; B = b; shamt = sh;
    @(negedge clk);
    start = 1'b0;
    // Inputs changing after the start edge must not disturb the operation.
    ALU_control = 4'($urandom); A = $urandom; B = $urandom; shamt = 5'($urandom);
    cyc = 1;
    while (!done && cyc < 200) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (poke && cyc == 2) begin
        start = 1'b1; ALU_control = 4'b0010; A = 32'h1; B = 32'h1; shamt = 5'd0;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(elat));
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_zero"}, 64'(zero), 64'(er == 32'd0));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    chk({tag, "_illegal"}, 64'(illegal), 64'(eil));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, 64'(result), 64'(er));
    $display("op %s code=%b A=%h B=%h sh=%0d -> result=%h zero=%b ovf=%b illegal=%b cycles=%0d",
             tag, op, a, b, sh, result, zero, ovf, illegal, cyc);
  endtask

  logic [3:0] codes [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1111, 4'b0101};

  initial begin
    // Reset state
    #12;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", 64'(done), 64'd0);
    end

    // Directed corners
    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0);
    run_op("sub_zero", 4'b0110, 32'h5, 32'h5, 5'd0, 1'b0);
    run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 5'd0, 1'b0);
    run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
    run_op("nor", 4'b1100, 32'h0F0F_0000, 32'h0000_F0F0, 5'd0, 1'b0);
    run_op("sll4_poke", 4'b1111, 32'h0, 32'h3, 5'd4, 1'b1);
    chk("sll4_value", 64'(result), 64'h30);
    run_op("sll0", 4'b1111, 32'h0, 32'h0000_ABCD, 5'd0, 1'b0);
    run_op("illegal_0101", 4'b0101, 32'h1234, 32'h5678, 5'd3, 1'b0);
    run_op("illegal_x", 4'bxxxx, 32'h1, 32'h2, 5'd0, 1'b0);

    // Reset during the second SHIFT cycle of sll by 8
    @(negedge clk);
    start = 1'b1; ALU_control = 4'b1111; B = 32'h1234_5678; shamt = 5'd8;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_shift_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_result", 64'(result), 64'd0);
    chk("async_rst_zero", 64'(zero), 64'd0);
    chk("async_rst_ovf", 64'(ovf), 64'd0);
    chk("async_rst_illegal", 64'(illegal), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    $display("reset asserted mid-shift: result=%h busy=%b done=%b", result, busy, done);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'(done), 64'd0);
      chk("no_busy_after_rst", 64'(busy), 64'd0);
    end

    // Random operations
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [31:0] ra, rb;
      int sel;
      sel = $urandom_range(0, 9);
      op = (sel < 8) ? codes[sel] : 4'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op("rand", op, ra, rb, 5'($urandom_range(0, 12)), ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH SHALL default to 32 and set the operand and result width.
REQ-003 Parameter SHAMT_W SHALL default to 5 and set the shift-amount width.
REQ-004 Port clk SHALL be an input, 1 bit: the rising-edge clock.
REQ-005 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port start SHALL be an input, 1 bit: request to begin an operation.
REQ-007 Port ALU_control SHALL be an input, 4 bits: operation code from the ALU control unit.
REQ-008 Port A SHALL be an input, WIDTH bits: operand rs.
REQ-009 Port B SHALL be an input, WIDTH bits: operand rt or immediate.
REQ-010 Port shamt SHALL be an input, SHAMT_W bits: shift amount for sll.
REQ-011 Port result SHALL be an output, WIDTH bits: registered result.
REQ-012 Port zero SHALL be an output, 1 bit: registered flag for result equal to 0.
REQ-013 Port ovf SHALL be an output, 1 bit: registered signed overflow for add and sub.
REQ-014 Port illegal SHALL be an output, 1 bit: registered flag for an unsupported code.
REQ-015 Port busy SHALL be an output, 1 bit: high while a multi-cycle shift is in progress.
REQ-016 Port done SHALL be an output, 1 bit: one-cycle completion pulse.

Function
REQ-017 The block SHALL decode these codes: 0010 add; 0110 sub; 0000 and; 0001 or; 1100 nor; 0111 slt; 1111 sll.
REQ-018 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-019 In IDLE or DONE, start=1 SHALL latch ALU_control, A, B and shamt at the clock edge.
REQ-020 A start for a non-shift code, or for sll with shamt=0, SHALL write the result, flags and illegal at that same edge and enter DONE; latency is 1 cycle.
REQ-021 A start for sll with shamt>0 SHALL load the accumulator with B and the counter with shamt, then enter SHIFT.
REQ-022 In SHIFT, each cycle SHALL shift the accumulator left by 1 with zero fill and decrement the counter.
REQ-023 When the counter reaches 0, SHIFT SHALL write the result and flags and enter DONE; total sll latency is shamt+1 cycles.
REQ-024 done SHALL be 1 only in DONE; DONE without start SHALL return to IDLE.
REQ-025 busy SHALL be 1 only in SHIFT; start while busy=1 SHALL be ignored with no effect.
REQ-026 add and sub SHALL wrap modulo 2^WIDTH.
REQ-027 ovf SHALL be set for add when the operand signs are equal and the result sign differs.
REQ-028 ovf SHALL be set for sub when the operand signs differ and the result sign differs from A.
REQ-029 ovf SHALL be 0 for all other codes.
REQ-030 slt SHALL compare signed and produce result 1 when A<B, otherwise 0.
REQ-031 nor SHALL produce ~(A|B).
REQ-032 An unsupported or X code SHALL produce result 0, zero=1, ovf=0, illegal=1 and latency 1.
REQ-033 zero SHALL be updated together with result: it equals 1 when the new result is 0.
REQ-034 result, zero, ovf and illegal SHALL hold their values until the next completion.
REQ-035 Input changes after the start edge SHALL NOT affect an operation in progress.

Reset
REQ-036 Asserting rst_n=0 SHALL immediately force state to IDLE, clear the counter and accumulator, and set result=0, zero=0, ovf=0, illegal=0, busy=0, done=0, including when asserted mid-SHIFT.
REQ-037 After rst_n is released, no done SHALL occur until a new start is accepted.

Verification
REQ-038 The bench SHALL cover: add A=7FFFFFFF, B=1 -> done 1 cycle after start, result=80000000, ovf=1, zero=0.
REQ-039 The bench SHALL cover: sub A=5, B=5 -> result=0, zero=1, ovf=0; slt A=FFFFFFFF, B=1 -> result=1.
REQ-040 The bench SHALL cover: sll B=00000003, shamt=4 -> busy for 4 cycles, done on cycle 5, result=00000030; a second start during busy is ignored.
REQ-041 The bench SHALL cover: sll shamt=0, B=ABCD -> done after 1 cycle, busy never 1, result=0000ABCD.
REQ-042 The bench SHALL cover: ALU_control=0101 -> illegal=1, result=0, zero=1 after 1 cycle.
REQ-043 The bench SHALL cover: rst_n=0 in the 2nd SHIFT cycle of sll shamt=8 -> all outputs 0 immediately, with no done after release.
